// File: rtl/programm_lader.sv
// programm_lader: boot loader that streams a length-prefixed image into instruction RAM
// and holds the CPU in reset until the load completes. Define PRUEFSUMME_EN for a trailing XOR checksum byte.
module programm_lader #(
    parameter int WORDS   = 256,
    parameter int TIMEOUT = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  ByteRein,
    input  logic        ByteGueltig,
    output logic        ByteBereit,
    output logic [31:0] Adresse,
    output logic [31:0] DatenRaus,
    output logic        SchreibenAn,
    input  logic        DatenGeschrieben,
    output logic        Initialisierung,
    output logic        CpuReset,
    output logic        Fertig,
    output logic        Fehler
);

`ifdef PRUEFSUMME_EN
    typedef enum logic [2:0] {
        KOPF_H   = 3'd0,
        KOPF_L   = 3'd1,
        WORT     = 3'd2,
        SCHREIBE = 3'd3,
        PRUEFE   = 3'd4,
        FERTIG   = 3'd5,
        FEHLER   = 3'd6
    } zustand_t;
`else
    typedef enum logic [2:0] {
        KOPF_H   = 3'd0,
        KOPF_L   = 3'd1,
        WORT     = 3'd2,
        SCHREIBE = 3'd3,
        FERTIG   = 3'd5,
        FEHLER   = 3'd6
    } zustand_t;
`endif

    localparam logic [15:0] MAX_WORTE = 16'(WORDS);
    localparam logic [15:0] WARTE_MAX = 16'(TIMEOUT - 1);

    zustand_t    zustand_r;
    logic [15:0] anzahl_r;
    logic [15:0] wortZaehler_r;
    logic [15:0] warteZaehler_r;
    logic [1:0]  byteZaehler_r;
    logic [23:0] schiebe_r;

    logic        annahme_s;
    logic [15:0] anzahlNeu_s;
    logic [15:0] wortNaechst_s;
    logic        letztesWort_s;

    assign annahme_s     = ByteGueltig && ByteBereit;
    assign anzahlNeu_s   = {anzahl_r[15:8], ByteRein};
    assign wortNaechst_s = wortZaehler_r + 16'd1;
    assign letztesWort_s = (wortNaechst_s == anzahl_r);

`ifdef PRUEFSUMME_EN
    logic [7:0] pruefsumme_r;

    function automatic logic [7:0] xorNeu(input logic [7:0] alt, input logic [7:0] neu);
        return alt ^ neu;
    endfunction

    // Running XOR over header and payload bytes; the checksum byte itself is excluded.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pruefsumme_r <= 8'h00;
        end else if (annahme_s && (zustand_r != PRUEFE)) begin
            pruefsumme_r <= xorNeu(pruefsumme_r, ByteRein);
        end else begin
            pruefsumme_r <= pruefsumme_r;
        end
    end
`endif

    // Loader state machine with all outputs registered.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zustand_r       <= KOPF_H;
            anzahl_r        <= 16'd0;
            wortZaehler_r   <= 16'd0;
            warteZaehler_r  <= 16'd0;
            byteZaehler_r   <= 2'd0;
            schiebe_r       <= 24'd0;
            ByteBereit      <= 1'b0;
            Adresse         <= 32'd0;
            DatenRaus       <= 32'd0;
            SchreibenAn     <= 1'b0;
            Initialisierung <= 1'b1;
            CpuReset        <= 1'b1;
            Fertig          <= 1'b0;
            Fehler          <= 1'b0;
        end else begin
            case (zustand_r)
                KOPF_H: begin
                    ByteBereit <= 1'b1;
                    if (annahme_s) begin
                        anzahl_r[15:8] <= ByteRein;
                        zustand_r      <= KOPF_L;
                    end else begin
                        zustand_r      <= KOPF_H;
                    end
                end
                KOPF_L: begin
                    if (annahme_s) begin
                        anzahl_r[7:0] <= ByteRein;
                        wortZaehler_r <= 16'd0;
                        byteZaehler_r <= 2'd0;
                        if (anzahlNeu_s == 16'd0) begin
`ifdef PRUEFSUMME_EN
                            zustand_r       <= PRUEFE;
`else
                            zustand_r       <= FERTIG;
                            ByteBereit      <= 1'b0;
                            Initialisierung <= 1'b0;
                            CpuReset        <= 1'b0;
                            Fertig          <= 1'b1;
`endif
                        end else if (anzahlNeu_s > MAX_WORTE) begin
                            zustand_r  <= FEHLER;
                            ByteBereit <= 1'b0;
                            Fehler     <= 1'b1;
                        end else begin
                            zustand_r  <= WORT;
                        end
                    end else begin
                        zustand_r <= KOPF_L;
                    end
                end
                WORT: begin
                    if (annahme_s) begin
                        schiebe_r     <= {schiebe_r[15:0], ByteRein};
                        byteZaehler_r <= byteZaehler_r + 2'd1;
                        if (byteZaehler_r == 2'd3) begin
                            zustand_r      <= SCHREIBE;
                            ByteBereit     <= 1'b0;
                            SchreibenAn    <= 1'b1;
                            DatenRaus      <= {schiebe_r, ByteRein};
                            Adresse        <= {16'h0000, wortZaehler_r};
                            warteZaehler_r <= 16'd0;
                        end else begin
                            zustand_r <= WORT;
                        end
                    end else begin
                        zustand_r <= WORT;
                    end
                end
                SCHREIBE: begin
                    // An acknowledge in the expiry cycle takes priority over the timeout.
                    if (DatenGeschrieben) begin
                        SchreibenAn   <= 1'b0;
                        wortZaehler_r <= wortNaechst_s;
                        if (letztesWort_s) begin
`ifdef PRUEFSUMME_EN
                            zustand_r       <= PRUEFE;
                            ByteBereit      <= 1'b1;
`else
                            zustand_r       <= FERTIG;
                            Initialisierung <= 1'b0;
                            CpuReset        <= 1'b0;
                            Fertig          <= 1'b1;
`endif
                        end else begin
                            zustand_r     <= WORT;
                            ByteBereit    <= 1'b1;
                            byteZaehler_r <= 2'd0;
                        end
                    end else if (warteZaehler_r == WARTE_MAX) begin
                        zustand_r   <= FEHLER;
                        SchreibenAn <= 1'b0;
                        Fehler      <= 1'b1;
                    end else begin
                        warteZaehler_r <= warteZaehler_r + 16'd1;
                    end
                end
`ifdef PRUEFSUMME_EN
                PRUEFE: begin
                    ByteBereit <= 1'b1;
                    if (annahme_s) begin
                        ByteBereit <= 1'b0;
                        if (ByteRein == pruefsumme_r) begin
                            zustand_r       <= FERTIG;
                            Initialisierung <= 1'b0;
                            CpuReset        <= 1'b0;
                            Fertig          <= 1'b1;
                        end else begin
                            zustand_r <= FEHLER;
                            Fehler    <= 1'b1;
                        end
                    end else begin
                        zustand_r <= PRUEFE;
                    end
                end
`endif
                FERTIG: begin
                    zustand_r  <= FERTIG;
                    ByteBereit <= 1'b0;
                end
                FEHLER: begin
                    zustand_r  <= FEHLER;
                    ByteBereit <= 1'b0;
                end
                default: begin
                    zustand_r       <= FEHLER;
                    ByteBereit      <= 1'b0;
                    SchreibenAn     <= 1'b0;
                    Initialisierung <= 1'b1;
                    CpuReset        <= 1'b1;
                    Fertig          <= 1'b0;
                    Fehler          <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_programm_lader.sv
// Self-checking bench for programm_lader: directed and random images against a byte-level image model.
module tb_programm_lader;
    localparam int WORDS   = 256;
    localparam int TIMEOUT = 64;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  ByteRein = 8'h00;
    logic        ByteGueltig = 1'b0;
    logic        DatenGeschrieben = 1'b0;
    logic        ByteBereit;
    logic [31:0] Adresse;
    logic [31:0] DatenRaus;
    logic        SchreibenAn;
    logic        Initialisierung;
    logic        CpuReset;
    logic        Fertig;
    logic        Fehler;

    programm_lader #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .ByteRein(ByteRein), .ByteGueltig(ByteGueltig),
        .ByteBereit(ByteBereit), .Adresse(Adresse), .DatenRaus(DatenRaus),
        .SchreibenAn(SchreibenAn), .DatenGeschrieben(DatenGeschrieben),
        .Initialisierung(Initialisierung), .CpuReset(CpuReset), .Fertig(Fertig), .Fehler(Fehler)
    );

    always #5 Clock = ~Clock;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] ram [0:WORDS-1];
    int          writeCount = 0;
    int          schreibZyklen = 0;
    int          waitCnt = 0;
    int          ackDelay = 2;
    bit          ackEnable = 1'b1;

    logic [7:0]  img[$];
    logic [31:0] expWords[$];
    int          expN;
    bit          expOk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RAM model: acknowledges each write request after ackDelay cycles.
    initial begin
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                DatenGeschrieben = 1'b0;
                waitCnt = 0;
                writeCount = 0;
                schreibZyklen = 0;
                for (int i = 0; i < WORDS; i++) ram[i] = 32'hDEAD_BEEF;
            end else begin
                if (SchreibenAn) schreibZyklen++;
                if (DatenGeschrieben) begin
                    DatenGeschrieben = 1'b0;
                    waitCnt = 0;
                end else if (SchreibenAn && ackEnable) begin
                    waitCnt++;
                    if (waitCnt >= ackDelay) begin
                        if (Adresse < 32'(WORDS)) ram[Adresse[7:0]] = DatenRaus;
                        writeCount++;
                        DatenGeschrieben = 1'b1;
                    end
                end else begin
                    waitCnt = 0;
                end
            end
        end
    end

    task automatic doReset();
        @(negedge Clock);
        Reset = 1'b0;
        ByteGueltig = 1'b0;
        ackEnable = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic sendByte(input logic [7:0] b);
        int t;
        t = 0;
        ByteRein = b;
        ByteGueltig = 1'b1;
        while (!ByteBereit && t < 500) begin
            @(negedge Clock);
            t++;
        end
        if (ByteBereit) @(negedge Clock);
        else chk("byte_accept_wait", 32'(ByteBereit), 32'd1);
        ByteGueltig = 1'b0;
    endtask

    task automatic buildImage(input int n);
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom_range(0, 255)));
    endtask

`ifdef PRUEFSUMME_EN
    task automatic appendChecksum(input bit corrupt);
        logic [7:0] x;
        x = 8'h00;
        foreach (img[i]) x = x ^ img[i];
        if (corrupt) x = x ^ 8'(1 << $urandom_range(0, 7));
        img.push_back(x);
    endtask
`endif

    // Image-level expectation: word count from header, words from byte groups, checksum by XOR.
    task automatic model();
        expN = (int'(img[0]) << 8) | int'(img[1]);
        expWords.delete();
        expOk = (expN <= WORDS);
        if (expOk) begin
            for (int k = 0; k < expN; k++)
                expWords.push_back({img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]});
`ifdef PRUEFSUMME_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 0; i < img.size() - 1; i++) x = x ^ img[i];
                expOk = (x == img[img.size()-1]);
            end
`endif
        end
    endtask

    task automatic runImage(input int delay);
        int t;
        int nSend;
        ackDelay = delay;
        doReset();
        model();
        nSend = (expN > WORDS) ? 2 : img.size();
        for (int i = 0; i < nSend; i++) sendByte(img[i]);
`ifndef PRUEFSUMME_EN
        if (expN > 0 && expN <= WORDS) begin
            #1;
            t = 0;
            while (writeCount < expN && t < 400) begin
                @(negedge Clock);
                #1;
                t++;
            end
            chk("cpureset_held_at_last_ack", 32'(CpuReset), 32'd1);
            @(negedge Clock);
            chk("cpureset_released_after_ack", 32'(CpuReset), 32'd0);
        end
`endif
        t = 0;
        while (!(Fertig || Fehler) && t < 400) begin
            @(negedge Clock);
            t++;
        end
        chk("fertig", 32'(Fertig), 32'(expOk));
        chk("fehler", 32'(Fehler), 32'(!expOk));
        chk("cpureset", 32'(CpuReset), 32'(!expOk));
        chk("initialisierung", 32'(Initialisierung), 32'(!expOk));
        chk("bytebereit_end", 32'(ByteBereit), 32'd0);
        chk("write_count", 32'(writeCount), 32'((expN <= WORDS) ? expN : 0));
        for (int k = 0; k < expWords.size(); k++)
            chk($sformatf("ram[%0d]", k), ram[k], expWords[k]);
    endtask

    task automatic checkResetValues(input string pfx);
        chk({pfx, "_bytebereit"}, 32'(ByteBereit), 32'd0);
        chk({pfx, "_schreibenan"}, 32'(SchreibenAn), 32'd0);
        chk({pfx, "_adresse"}, Adresse, 32'd0);
        chk({pfx, "_datenraus"}, DatenRaus, 32'd0);
        chk({pfx, "_init"}, 32'(Initialisierung), 32'd1);
        chk({pfx, "_cpureset"}, 32'(CpuReset), 32'd1);
        chk({pfx, "_fertig"}, 32'(Fertig), 32'd0);
        chk({pfx, "_fehler"}, 32'(Fehler), 32'd0);
    endtask

    initial begin
        // Power-on reset values and first ready edge.
        repeat (2) @(negedge Clock);
        checkResetValues("rst");
        Reset = 1'b1;
        @(negedge Clock);
        chk("bytebereit_after_reset", 32'(ByteBereit), 32'd1);

        // Two-word example image.
        img = '{8'h00, 8'h02, 8'h80, 8'h40, 8'h00, 8'h0F, 8'h00, 8'h20, 8'h00, 8'h00};
`ifdef PRUEFSUMME_EN
        appendChecksum(1'b0);
`endif
        runImage(2);
        chk("ex_ram0", ram[0], 32'h8040000F);
        chk("ex_ram1", ram[1], 32'h00200000);

        // Empty image: no writes at all.
        buildImage(0);
`ifdef PRUEFSUMME_EN
        appendChecksum(1'b0);
`endif
        runImage(1);
        chk("empty_no_schreibenan", 32'(schreibZyklen), 32'd0);

        // Oversized header.
        img = '{8'h01, 8'h01};
        runImage(1);
        chk("oversize_no_write", 32'(schreibZyklen), 32'd0);

        // Write timeout with the RAM never acknowledging.
        ackDelay = 1;
        doReset();
        ackEnable = 1'b0;
        buildImage(1);
        for (int i = 0; i < 6; i++) sendByte(img[i]);
        chk("to_schreibenan_rise", 32'(SchreibenAn), 32'd1);
        repeat (TIMEOUT - 1) @(negedge Clock);
        chk("to_fehler_before", 32'(Fehler), 32'd0);
        chk("to_schreibenan_before", 32'(SchreibenAn), 32'd1);
        @(negedge Clock);
        chk("to_fehler", 32'(Fehler), 32'd1);
        chk("to_schreibenan_drop", 32'(SchreibenAn), 32'd0);
        chk("to_cpureset", 32'(CpuReset), 32'd1);
        chk("to_init", 32'(Initialisierung), 32'd1);
        ackEnable = 1'b1;

        // Asynchronous reset while the third byte of word 1 is offered, then a full reload.
        ackDelay = 2;
        doReset();
        buildImage(2);
        for (int i = 0; i < 8; i++) sendByte(img[i]);
        ByteRein = 8'hA5;
        ByteGueltig = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        checkResetValues("midrst");
        ByteGueltig = 1'b0;
        buildImage(3);
`ifdef PRUEFSUMME_EN
        appendChecksum(1'b0);
`endif
        runImage(3);

`ifdef PRUEFSUMME_EN
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        runImage(1);
        chk("cs_good_fertig", 32'(Fertig), 32'd1);
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        runImage(1);
        chk("cs_bad_cpureset", 32'(CpuReset), 32'd1);
`endif

        // Random images with random acknowledge latency.
        for (int r = 0; r < 8; r++) begin
            buildImage($urandom_range(1, 6));
`ifdef PRUEFSUMME_EN
            appendChecksum($urandom_range(0, 3) == 0);
`endif
            runImage($urandom_range(1, 4));
        end

        // Full-depth image.
        buildImage(WORDS);
`ifdef PRUEFSUMME_EN
        appendChecksum(1'b0);
`endif
        runImage(1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
